mem_xbar: RTL and testbench

Parametrised successor to the single-cycle memory controller. It connects two CPU masters, an instruction fetch port and a data load/store port, to NUM_SLAVES memory or peripheral slaves. Each slave uses a req/ack handshake with variable latency. The block provides:
- decode of address bits [31:28]
- per-slave arbitration
- store byte-lane generation
- load alignment and sign/zero extension
- fault reporting for unmapped or misaligned accesses

---
 rtl/mem_xbar_pkg.sv | 80 ++++++++
 rtl/mem_xbar_if.sv | 51 +++++
 rtl/mem_xbar_master_fsm.sv | 118 +++++++++++
 rtl/mem_xbar.sv | 126 ++++++++++++
 tb/tb_mem_xbar.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_xbar_pkg.sv
// Shared types and helpers for the two-master memory crossbar.
// Holds the address decode, the store lane builder and the load formatter.
package mem_xbar_pkg;

  localparam int MAX_SLAVES = 8;

  localparam logic [1:0] W_BYTE = 2'd1;
  localparam logic [1:0] W_HALF = 2'd2;
  localparam logic [1:0] W_WORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mst_state_e;

  typedef struct packed {
    logic                  hit;
    logic [MAX_SLAVES-1:0] sel;
  } dec_t;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] wdata;
  } lanes_t;

  // First matching base wins, so overlapping bases still give a one-hot select.
  function automatic dec_t decode_slave(input logic [3:0] addr_hi,
                                        input logic [4*MAX_SLAVES-1:0] base,
                                        input int n);
    dec_t d;
    d = '0;
    for (int k = 0; k < MAX_SLAVES; k++) begin
      if (k < n && !d.hit && addr_hi == base[4*k +: 4]) begin
        d.hit    = 1'b1;
        d.sel[k] = 1'b1;
      end
    end
    return d;
  endfunction

  function automatic lanes_t store_lanes(input logic [31:0] data,
                                         input logic [1:0]  width,
                                         input logic [1:0]  off);
    lanes_t l;
    case (width)
      W_BYTE: begin
        l.be    = 4'b0001 << off;
        l.wdata = {4{data[7:0]}};
      end
      W_HALF: begin
        l.be    = off[1] ? 4'b1100 : 4'b0011;
        l.wdata = {2{data[15:0]}};
      end
      default: begin
        l.be    = 4'b1111;
        l.wdata = data;
      end
    endcase
    return l;
  endfunction

  function automatic logic [31:0] format_load(input logic [31:0] rdata,
                                              input logic [1:0]  width,
                                              input logic [1:0]  off,
                                              input logic        zext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (width)
      W_BYTE:  r = zext ? {24'h0, b} : {{24{b[7]}}, b};
      W_HALF:  r = zext ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_xbar_if.sv
// CPU-side and slave-side signal bundle of the crossbar.
// slave = crossbar side, master = environment (CPU core + memories).
interface mem_xbar_if #(
  parameter int NUM_SLAVES = 4,
  parameter int SLAVE_AW   = 28
);
  logic [31:0]                          i_inst_addr;
  logic                                 i_inst_re;
  logic [31:0]                          o_inst_data;
  logic                                 o_inst_valid;
  logic                                 o_inst_fault;
  logic                                 o_inst_stall;

  logic [31:0]                          i_data_addr;
  logic [31:0]                          i_data_data;
  logic [1:0]                           i_data_width;
  logic                                 i_data_we;
  logic                                 i_data_re;
  logic                                 i_data_zeroextend;
  logic [31:0]                          o_data_data;
  logic                                 o_data_valid;
  logic                                 o_data_fault;
  logic                                 o_data_stall;

  logic [NUM_SLAVES-1:0]                o_s_req;
  logic [NUM_SLAVES-1:0]                o_s_we;
  logic [NUM_SLAVES-1:0][SLAVE_AW-1:0]  o_s_addr;
  logic [NUM_SLAVES-1:0][31:0]          o_s_wdata;
  logic [NUM_SLAVES-1:0][3:0]           o_s_be;
  logic [NUM_SLAVES-1:0]                i_s_ack;
  logic [NUM_SLAVES-1:0][31:0]          i_s_rdata;

  modport slave (
    input  i_inst_addr, i_inst_re,
    output o_inst_data, o_inst_valid, o_inst_fault, o_inst_stall,
    input  i_data_addr, i_data_data, i_data_width, i_data_we, i_data_re, i_data_zeroextend,
    output o_data_data, o_data_valid, o_data_fault, o_data_stall,
    output o_s_req, o_s_we, o_s_addr, o_s_wdata, o_s_be,
    input  i_s_ack, i_s_rdata
  );

  modport master (
    output i_inst_addr, i_inst_re,
    input  o_inst_data, o_inst_valid, o_inst_fault, o_inst_stall,
    output i_data_addr, i_data_data, i_data_width, i_data_we, i_data_re, i_data_zeroextend,
    input  o_data_data, o_data_valid, o_data_fault, o_data_stall,
    input  o_s_req, o_s_we, o_s_addr, o_s_wdata, o_s_be,
    output i_s_ack, i_s_rdata
  );

endinterface

// File: rtl/mem_xbar_master_fsm.sv
// One CPU master port: decode/fault check, request latch, response formatting.
// Used for both fetch (write path tied off) and data ports.
module mem_xbar_master_fsm
  import mem_xbar_pkg::*;
#(
  parameter int                        NUM_SLAVES = 4,
  parameter logic [4*NUM_SLAVES-1:0]   SLAVE_BASE = {4'h8, 4'h4, 4'h2, 4'h1},
  parameter logic [NUM_SLAVES-1:0]     ACC_MASK   = '1,
  parameter int                        SLAVE_AW   = 28
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [31:0]           i_addr,
  input  logic [31:0]           i_wdata,
  input  logic [1:0]            i_width,
  input  logic                  i_we,
  input  logic                  i_re,
  input  logic                  i_zext,
  input  logic                  i_ack,
  input  logic [31:0]           i_rdata,
  output logic                  o_wait,
  output logic [NUM_SLAVES-1:0] o_sel,
  output logic [SLAVE_AW-1:0]   o_addr,
  output logic                  o_we,
  output logic [3:0]            o_be,
  output logic [31:0]           o_wdata,
  output logic [31:0]           o_data,
  output logic                  o_valid,
  output logic                  o_fault,
  output logic                  o_stall
);

  localparam logic [4*MAX_SLAVES-1:0] BASE_X = (4*MAX_SLAVES)'(SLAVE_BASE);
  localparam logic [MAX_SLAVES-1:0]   MASK_X = MAX_SLAVES'(ACC_MASK);

  mst_state_e            r_state, w_nxt;
  logic [NUM_SLAVES-1:0] r_sel;
  logic [SLAVE_AW-1:0]   r_addr;
  logic                  r_we;
  logic [3:0]            r_be;
  logic [31:0]           r_wdata;
  logic [1:0]            r_width;
  logic [1:0]            r_off;
  logic                  r_zext;
  logic                  r_fault;
  logic [31:0]           r_rdata;

  dec_t   w_dec;
  lanes_t w_lanes;
  logic   w_req, w_mis, w_fault;

  assign w_req   = i_re | i_we;
  assign w_dec   = decode_slave(i_addr[31:28], BASE_X, NUM_SLAVES);
  assign w_lanes = store_lanes(i_wdata, i_width, i_addr[1:0]);
  assign w_mis   = (i_width == W_HALF) ? i_addr[0] :
                   (i_width == W_BYTE) ? 1'b0 : (i_addr[1:0] != 2'b00);
  // Mask check also rejects slaves this port is not allowed to reach.
  assign w_fault = !w_dec.hit || !(|(w_dec.sel & MASK_X)) || w_mis;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_nxt;
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_req) w_nxt = w_fault ? ST_RESP : ST_WAIT;
      ST_WAIT: if (i_ack) w_nxt = ST_RESP;
      ST_RESP: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sel   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_wdata <= '0;
      r_width <= '0;
      r_off   <= '0;
      r_zext  <= 1'b0;
      r_fault <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_req) begin
          r_fault <= w_fault;
          r_rdata <= '0;
          r_sel   <= w_fault ? '0 : w_dec.sel[NUM_SLAVES-1:0];
          r_addr  <= i_addr[SLAVE_AW-1:0];
          r_we    <= i_we;
          r_be    <= i_we ? w_lanes.be : 4'b1111;
          r_wdata <= i_we ? w_lanes.wdata : '0;
          r_width <= i_width;
          r_off   <= i_addr[1:0];
          r_zext  <= i_zext;
        end
        ST_WAIT: if (i_ack) r_rdata <= r_we ? '0 : format_load(i_rdata, r_width, r_off, r_zext);
        default: ;
      endcase
    end
  end

  assign o_wait  = (r_state == ST_WAIT);
  assign o_sel   = r_sel;
  assign o_addr  = r_addr;
  assign o_we    = r_we;
  assign o_be    = r_be;
  assign o_wdata = r_wdata;
  assign o_valid = (r_state == ST_RESP);
  assign o_fault = o_valid & r_fault;
  assign o_data  = o_valid ? r_rdata : '0;
  assign o_stall = w_req && (r_state != ST_RESP);

endmodule

// File: rtl/mem_xbar.sv
// Two-master (fetch + data) to NUM_SLAVES crossbar with per-slave grant lock
// and fixed-priority or round-robin arbitration.
module mem_xbar
  import mem_xbar_pkg::*;
#(
  parameter int                      NUM_SLAVES = 4,
  parameter logic [4*NUM_SLAVES-1:0] SLAVE_BASE = {4'h8, 4'h4, 4'h2, 4'h1},
  parameter logic [NUM_SLAVES-1:0]   INST_MASK  = 4'b0011,
  parameter int                      ARB_MODE   = 0,
  parameter int                      SLAVE_AW   = 28
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  mem_xbar_if.slave bus
);

  logic                  w_d_wait, w_i_wait;
  logic [NUM_SLAVES-1:0] w_d_sel, w_i_sel;
  logic [SLAVE_AW-1:0]   w_d_addr, w_i_addr;
  logic                  w_d_we, w_i_we;
  logic [3:0]            w_d_be, w_i_be;
  logic [31:0]           w_d_wdata, w_i_wdata;
  logic                  w_d_ack, w_i_ack;
  logic [31:0]           w_d_rdata, w_i_rdata;

  logic [NUM_SLAVES-1:0] w_want_d, w_want_i, w_gnt_d, w_gnt_i, w_req;
  logic [NUM_SLAVES-1:0] r_lock, r_own_i, r_rr;

  mem_xbar_master_fsm #(
    .NUM_SLAVES(NUM_SLAVES), .SLAVE_BASE(SLAVE_BASE),
    .ACC_MASK('1), .SLAVE_AW(SLAVE_AW)
  ) u_data (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_addr(bus.i_data_addr), .i_wdata(bus.i_data_data), .i_width(bus.i_data_width),
    .i_we(bus.i_data_we), .i_re(bus.i_data_re), .i_zext(bus.i_data_zeroextend),
    .i_ack(w_d_ack), .i_rdata(w_d_rdata),
    .o_wait(w_d_wait), .o_sel(w_d_sel), .o_addr(w_d_addr), .o_we(w_d_we),
    .o_be(w_d_be), .o_wdata(w_d_wdata),
    .o_data(bus.o_data_data), .o_valid(bus.o_data_valid),
    .o_fault(bus.o_data_fault), .o_stall(bus.o_data_stall)
  );

  mem_xbar_master_fsm #(
    .NUM_SLAVES(NUM_SLAVES), .SLAVE_BASE(SLAVE_BASE),
    .ACC_MASK(INST_MASK), .SLAVE_AW(SLAVE_AW)
  ) u_inst (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_addr(bus.i_inst_addr), .i_wdata(32'h0), .i_width(W_WORD),
    .i_we(1'b0), .i_re(bus.i_inst_re), .i_zext(1'b0),
    .i_ack(w_i_ack), .i_rdata(w_i_rdata),
    .o_wait(w_i_wait), .o_sel(w_i_sel), .o_addr(w_i_addr), .o_we(w_i_we),
    .o_be(w_i_be), .o_wdata(w_i_wdata),
    .o_data(bus.o_inst_data), .o_valid(bus.o_inst_valid),
    .o_fault(bus.o_inst_fault), .o_stall(bus.o_inst_stall)
  );

  assign w_want_d = w_d_wait ? w_d_sel : '0;
  assign w_want_i = w_i_wait ? w_i_sel : '0;

  // A locked slave stays with its owner until ack; a free slave is arbitrated
  // among the masters currently waiting on it.
  always_comb begin
    w_gnt_d = '0;
    w_gnt_i = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (r_lock[k]) begin
        w_gnt_i[k] = r_own_i[k] & w_want_i[k];
        w_gnt_d[k] = !r_own_i[k] & w_want_d[k];
      end else if (w_want_d[k] && w_want_i[k]) begin
        if (ARB_MODE == 1 && r_rr[k]) w_gnt_i[k] = 1'b1;
        else                          w_gnt_d[k] = 1'b1;
      end else begin
        w_gnt_d[k] = w_want_d[k];
        w_gnt_i[k] = w_want_i[k];
      end
    end
  end

  assign w_req       = w_gnt_d | w_gnt_i;
  assign bus.o_s_req = w_req;
  assign w_d_ack     = |(bus.i_s_ack & w_gnt_d);
  assign w_i_ack     = |(bus.i_s_ack & w_gnt_i);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lock  <= '0;
      r_own_i <= '0;
      r_rr    <= '0;
    end else begin
      for (int k = 0; k < NUM_SLAVES; k++) begin
        if (w_req[k] && bus.i_s_ack[k]) begin
          r_lock[k] <= 1'b0;
        end else if (w_req[k]) begin
          r_lock[k]  <= 1'b1;
          r_own_i[k] <= w_gnt_i[k];
        end
        if (!r_lock[k] && w_want_d[k] && w_want_i[k]) r_rr[k] <= ~r_rr[k];
      end
    end
  end

  always_comb begin
    bus.o_s_we    = '0;
    bus.o_s_addr  = '0;
    bus.o_s_be    = '0;
    bus.o_s_wdata = '0;
    w_d_rdata     = '0;
    w_i_rdata     = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (w_gnt_d[k]) begin
        bus.o_s_we[k]    = w_d_we;
        bus.o_s_addr[k]  = w_d_addr;
        bus.o_s_be[k]    = w_d_be;
        bus.o_s_wdata[k] = w_d_wdata;
        w_d_rdata        = bus.i_s_rdata[k];
      end else if (w_gnt_i[k]) begin
        bus.o_s_we[k]    = w_i_we;
        bus.o_s_addr[k]  = w_i_addr;
        bus.o_s_be[k]    = w_i_be;
        bus.o_s_wdata[k] = w_i_wdata;
        w_i_rdata        = bus.i_s_rdata[k];
      end
    end
  end

endmodule

// File: tb/tb_mem_xbar.sv
// Directed bench: dut_a fixed priority with hand-driven slaves,
// dut_b round-robin for the alternating-conflict case.
module tb_mem_xbar;
  import mem_xbar_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  mem_xbar_if #(.NUM_SLAVES(4), .SLAVE_AW(28)) bus_a ();
  mem_xbar_if #(.NUM_SLAVES(4), .SLAVE_AW(28)) bus_b ();

  mem_xbar #(.NUM_SLAVES(4), .SLAVE_BASE(16'h8421), .INST_MASK(4'b0011),
             .ARB_MODE(0), .SLAVE_AW(28))
    dut_a (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));

  mem_xbar #(.NUM_SLAVES(4), .SLAVE_BASE(16'h8421), .INST_MASK(4'b0011),
             .ARB_MODE(1), .SLAVE_AW(28))
    dut_b (.i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_data(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] width, input logic we, input logic zext,
                          input int k, input logic [31:0] rd, input logic [31:0] exp_data,
                          input logic [3:0] exp_be, input logic [31:0] exp_wd);
    logic [27:0] exp_addr;
    exp_addr = addr[27:0];
    bus_a.i_data_addr = addr;  bus_a.i_data_data = wd;  bus_a.i_data_width = width;
    bus_a.i_data_we = we;      bus_a.i_data_re = !we;   bus_a.i_data_zeroextend = zext;
    tick();
    chk({tag, "_req"},   bus_a.o_s_req, 32'(1) << k);
    chk({tag, "_addr"},  bus_a.o_s_addr[k], exp_addr);
    chk({tag, "_be"},    bus_a.o_s_be[k], exp_be);
    chk({tag, "_we"},    bus_a.o_s_we[k], we);
    if (we) chk({tag, "_wd"}, bus_a.o_s_wdata[k], exp_wd);
    chk({tag, "_stall"}, bus_a.o_data_stall, 1);
    tick();
    bus_a.i_s_ack[k] = 1'b1;  bus_a.i_s_rdata[k] = rd;
    tick();
    chk({tag, "_vld"},   bus_a.o_data_valid, 1);
    chk({tag, "_flt"},   bus_a.o_data_fault, 0);
    if (!we) chk({tag, "_data"}, bus_a.o_data_data, exp_data);
    bus_a.i_s_ack[k] = 1'b0;  bus_a.i_data_re = 1'b0;  bus_a.i_data_we = 1'b0;
    tick();
    chk({tag, "_vld0"},  bus_a.o_data_valid, 0);
    chk({tag, "_data0"}, bus_a.o_data_data, 0);
  endtask

  task automatic run_fault(input string tag, input logic is_inst, input logic [31:0] addr,
                           input logic [1:0] width);
    if (is_inst) begin
      bus_a.i_inst_addr = addr;  bus_a.i_inst_re = 1'b1;
    end else begin
      bus_a.i_data_addr = addr;  bus_a.i_data_width = width;  bus_a.i_data_re = 1'b1;
    end
    #1;
    chk({tag, "_req_t0"}, bus_a.o_s_req, 0);
    tick();
    chk({tag, "_req"},  bus_a.o_s_req, 0);
    chk({tag, "_vld"},  is_inst ? bus_a.o_inst_valid : bus_a.o_data_valid, 1);
    chk({tag, "_flt"},  is_inst ? bus_a.o_inst_fault : bus_a.o_data_fault, 1);
    chk({tag, "_data"}, is_inst ? bus_a.o_inst_data  : bus_a.o_data_data, 0);
    bus_a.i_inst_re = 1'b0;  bus_a.i_data_re = 1'b0;
    tick();
    chk({tag, "_vld0"}, is_inst ? bus_a.o_inst_valid : bus_a.o_data_valid, 0);
  endtask

  task automatic conflict_b(input string tag, input logic inst_first);
    logic [27:0] a_first, a_second;
    a_first  = inst_first ? 28'h0 : 28'h4;
    a_second = inst_first ? 28'h4 : 28'h0;
    bus_b.i_inst_addr = 32'h2000_0000;  bus_b.i_inst_re = 1'b1;
    bus_b.i_data_addr = 32'h2000_0004;  bus_b.i_data_width = W_WORD;  bus_b.i_data_re = 1'b1;
    tick();
    chk({tag, "_req"},   bus_b.o_s_req, 4'b0010);
    chk({tag, "_addr1"}, bus_b.o_s_addr[1], a_first);
    tick();
    bus_b.i_s_ack[1] = 1'b1;  bus_b.i_s_rdata[1] = 32'h5555_AAAA;
    tick();
    chk({tag, "_v1_i"},  bus_b.o_inst_valid, inst_first);
    chk({tag, "_v1_d"},  bus_b.o_data_valid, !inst_first);
    chk({tag, "_addr2"}, bus_b.o_s_addr[1], a_second);
    bus_b.i_s_ack[1] = 1'b0;
    if (inst_first) bus_b.i_inst_re = 1'b0; else bus_b.i_data_re = 1'b0;
    tick();
    bus_b.i_s_ack[1] = 1'b1;
    tick();
    chk({tag, "_v2_i"},  bus_b.o_inst_valid, !inst_first);
    chk({tag, "_v2_d"},  bus_b.o_data_valid, inst_first);
    bus_b.i_s_ack[1] = 1'b0;  bus_b.i_inst_re = 1'b0;  bus_b.i_data_re = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus_a.i_inst_addr = '0; bus_a.i_inst_re = 0; bus_a.i_data_addr = '0; bus_a.i_data_data = '0;
    bus_a.i_data_width = '0; bus_a.i_data_we = 0; bus_a.i_data_re = 0; bus_a.i_data_zeroextend = 0;
    bus_a.i_s_ack = '0; bus_a.i_s_rdata = '0;
    bus_b.i_inst_addr = '0; bus_b.i_inst_re = 0; bus_b.i_data_addr = '0; bus_b.i_data_data = '0;
    bus_b.i_data_width = '0; bus_b.i_data_we = 0; bus_b.i_data_re = 0; bus_b.i_data_zeroextend = 0;
    bus_b.i_s_ack = '0; bus_b.i_s_rdata = '0;

    // Reset held with a fetch pending
    bus_a.i_inst_addr = 32'h1000_0004;  bus_a.i_inst_re = 1'b1;
    tick(); tick();
    chk("rst_req",   bus_a.o_s_req, 0);
    chk("rst_ivld",  bus_a.o_inst_valid, 0);
    chk("rst_dvld",  bus_a.o_data_valid, 0);
    chk("rst_idata", bus_a.o_inst_data, 0);
    chk("rst_stall", bus_a.o_inst_stall, 1);
    rst_n = 1'b1;  bus_a.i_s_ack = 4'hF;
    tick();
    chk("f0_req",   bus_a.o_s_req, 4'b0001);
    chk("f0_vld_w", bus_a.o_inst_valid, 0);
    chk("f0_addr",  bus_a.o_s_addr[0], 28'h000_0004);
    chk("f0_be",    bus_a.o_s_be[0], 4'hF);
    bus_a.i_s_ack = '0;
    tick();
    chk("f0_hold",  bus_a.o_s_req, 4'b0001);
    bus_a.i_s_ack[0] = 1'b1;  bus_a.i_s_rdata[0] = 32'h1234_5678;
    tick();
    chk("f0_vld",   bus_a.o_inst_valid, 1);
    chk("f0_data",  bus_a.o_inst_data, 32'h1234_5678);
    chk("f0_flt",   bus_a.o_inst_fault, 0);
    chk("f0_stall", bus_a.o_inst_stall, 0);
    chk("f0_req0",  bus_a.o_s_req, 0);
    bus_a.i_s_ack = '0;  bus_a.i_inst_re = 1'b0;
    tick();
    chk("f0_vld0",  bus_a.o_inst_valid, 0);
    chk("f0_data0", bus_a.o_inst_data, 0);

    // Round-robin alternation on repeated conflicts
    conflict_b("rr1", 1'b0);
    conflict_b("rr2", 1'b1);
    conflict_b("rr3", 1'b0);

    run_data("lb_s",  32'h4000_0003, 32'h0, W_BYTE, 1'b0, 1'b0, 2, 32'h80FF_0000, 32'hFFFF_FF80, 4'hF, 32'h0);
    run_data("lb_z",  32'h4000_0003, 32'h0, W_BYTE, 1'b0, 1'b1, 2, 32'h80FF_0000, 32'h0000_0080, 4'hF, 32'h0);
    run_data("lh_s",  32'h2000_0002, 32'h0, W_HALF, 1'b0, 1'b0, 1, 32'h8001_1234, 32'hFFFF_8001, 4'hF, 32'h0);
    run_data("lw",    32'h1000_0008, 32'h0, W_WORD, 1'b0, 1'b0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'hF, 32'h0);
    run_data("sh",    32'h8000_0012, 32'h0000_BEEF, W_HALF, 1'b1, 1'b0, 3, 32'h0, 32'h0, 4'b1100, 32'hBEEF_BEEF);
    run_data("sb",    32'h8000_0001, 32'h0000_00A5, W_BYTE, 1'b1, 1'b0, 3, 32'h0, 32'h0, 4'b0010, 32'hA5A5_A5A5);

    run_fault("f_mask",  1'b1, 32'h4000_0000, W_WORD);
    run_fault("f_ialgn", 1'b1, 32'h1000_0002, W_WORD);
    run_fault("d_walgn", 1'b0, 32'h4000_0002, W_WORD);
    run_fault("d_halgn", 1'b0, 32'h4000_0001, W_HALF);
    run_fault("d_unmap", 1'b0, 32'h3000_0000, W_WORD);

    // Fixed priority: data first, fetch after the data ack
    bus_a.i_inst_addr = 32'h2000_0000;  bus_a.i_inst_re = 1'b1;
    bus_a.i_data_addr = 32'h2000_0004;  bus_a.i_data_width = W_WORD;  bus_a.i_data_re = 1'b1;
    tick();
    chk("cf_req",   bus_a.o_s_req, 4'b0010);
    chk("cf_addr",  bus_a.o_s_addr[1], 28'h4);
    chk("cf_istl",  bus_a.o_inst_stall, 1);
    tick();
    bus_a.i_s_ack[1] = 1'b1;  bus_a.i_s_rdata[1] = 32'h1111_1111;
    tick();
    chk("cf_dvld",  bus_a.o_data_valid, 1);
    chk("cf_ddata", bus_a.o_data_data, 32'h1111_1111);
    chk("cf_ivld",  bus_a.o_inst_valid, 0);
    chk("cf_addr2", bus_a.o_s_addr[1], 28'h0);
    bus_a.i_s_ack[1] = 1'b0;  bus_a.i_data_re = 1'b0;
    tick();
    bus_a.i_s_ack[1] = 1'b1;  bus_a.i_s_rdata[1] = 32'h2222_2222;
    tick();
    chk("cf_ivld2", bus_a.o_inst_valid, 1);
    chk("cf_idata", bus_a.o_inst_data, 32'h2222_2222);
    bus_a.i_s_ack[1] = 1'b0;  bus_a.i_inst_re = 1'b0;
    tick();

    // Reset while waiting on slave 2, then a late ack
    bus_a.i_data_addr = 32'h4000_0000;  bus_a.i_data_width = W_WORD;  bus_a.i_data_re = 1'b1;
    tick();
    chk("rw_req",   bus_a.o_s_req, 4'b0100);
    rst_n = 1'b0;  bus_a.i_data_re = 1'b0;
    tick();
    chk("rw_req0",  bus_a.o_s_req, 0);
    chk("rw_vld0",  bus_a.o_data_valid, 0);
    rst_n = 1'b1;  bus_a.i_s_ack[2] = 1'b1;  bus_a.i_s_rdata[2] = 32'hCAFE_F00D;
    tick();
    chk("rw_late_vld",  bus_a.o_data_valid, 0);
    chk("rw_late_data", bus_a.o_data_data, 0);
    chk("rw_late_req",  bus_a.o_s_req, 0);
    bus_a.i_s_ack = '0;
    tick();
    chk("rw_vld_end", bus_a.o_data_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
